// File: rtl/prog_sequencer.sv
// Instruction sequencer feeding the bus processor: a 16-word program store
// loaded from switches, replayed one instruction at a time over DIN/Run/Done.
module prog_sequencer #(
  parameter int         ADDR_W    = 4,
  parameter int         TIMEOUT   = 64,
  parameter logic [7:0] HALT_WORD = 8'hFF
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Load,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [7:0]        LoadData,
  input  logic              Start,
  input  logic              Done,
  input  logic [7:0]        BusWires,
  output logic [7:0]        DIN,
  output logic              Run,
  output logic [ADDR_W-1:0] PC,
  output logic [7:0]        Result,
  output logic              Busy,
  output logic              Halted,
  output logic              Err
);

  localparam int         DEPTH  = 1 << ADDR_W;
  localparam int         CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [1:0] OP_MVI = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_IMM, S_WAIT, S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        din_q, din_d;
  logic [7:0]        result_q, result_d;
  logic              run_q, run_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [7:0]        mem_q [DEPTH];
  logic              mem_we;

  logic [ADDR_W-1:0] pc_inc1, pc_inc2;
  logic [7:0]        fetch_w, imm_w;

  // PC arithmetic wraps naturally at the address width
  assign pc_inc1 = pc_q + ADDR_W'(1);
  assign pc_inc2 = pc_q + ADDR_W'(2);
  assign fetch_w = mem_q[pc_q];
  assign imm_w   = mem_q[pc_inc1];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    din_d    = din_q;
    result_d = result_q;
    run_d    = 1'b0;
    err_d    = err_q;
    cnt_d    = cnt_q;
    mem_we   = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        mem_we = Load;
        if (Start) begin
          pc_d    = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (fetch_w == HALT_WORD) begin
          state_d = S_HALT;
        end else begin
          din_d   = fetch_w;
          run_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (din_q[7:6] == OP_MVI) begin
          din_d   = imm_w;
          state_d = S_IMM;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_IMM, S_WAIT: begin
        if (Done) begin
          result_d = BusWires;
          pc_d     = (state_q == S_IMM) ? pc_inc2 : pc_inc1;
          cnt_d    = '0;
          state_d  = S_FETCH;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // this is the TIMEOUT-th cycle without Done; PC keeps the faulting address
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d   = (state_d == S_ISSUE) || (state_d == S_IMM) || (state_d == S_WAIT);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      din_q    <= '0;
      result_q <= '0;
      run_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      din_q    <= din_d;
      result_q <= result_d;
      run_q    <= run_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  // Program store survives reset so a loaded program can be rerun
  always_ff @(posedge Clock) begin
    if (mem_we) mem_q[LoadAddr] <= LoadData;
  end

  assign DIN    = din_q;
  assign Run    = run_q;
  assign PC     = pc_q;
  assign Result = result_q;
  assign Busy   = busy_q;
  assign Halted = halted_q;
  assign Err    = err_q;

endmodule
